vm_input_conditioner: RTL and testbench

Front-end stage that feeds the vending-machine controller. It synchronises and debounces the raw L/R/C push-buttons and the four coin switches. It emits a single-cycle pulse per genuine button press and a serialized stream of coin events (value + valid), so the controller sees exactly one event per physical action.

---
 rtl/vm_pkg.sv | 21 ++
 rtl/vm_debounce_ch.sv | 49 ++++
 rtl/vm_input_conditioner.sv | 82 ++++++++
 tb/tb_vm_input_conditioner.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared constants for the vending-machine input front end:
// coin encodings and debounce channel indices.
package vm_pkg;

    localparam int COIN_W = 5;

    localparam logic [COIN_W-1:0] COIN_VAL_1  = 5'd1;
    localparam logic [COIN_W-1:0] COIN_VAL_5  = 5'd5;
    localparam logic [COIN_W-1:0] COIN_VAL_10 = 5'd10;
    localparam logic [COIN_W-1:0] COIN_VAL_20 = 5'd20;

    localparam int CH_L   = 0;
    localparam int CH_R   = 1;
    localparam int CH_C   = 2;
    localparam int CH_SW0 = 3;
    localparam int CH_SW1 = 4;
    localparam int CH_SW2 = 5;
    localparam int CH_SW3 = 6;
    localparam int NUM_CH = 7;

endpackage

// File: rtl/vm_debounce_ch.sv
// One input channel: 2-flop synchronizer, stability counter,
// accepted level and a registered one-cycle rise pulse.
module vm_debounce_ch #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic             sync;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta     <= 1'b0;
            sync     <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
            pulse    <= 1'b0;
        end else begin
            meta     <= raw;
            sync     <= meta;
            stable_d <= stable;
            pulse    <= stable & ~stable_d;
            // Any sample matching the accepted level restarts the count
            if (sync == stable) begin
                cnt <= '0;
            end else if (cnt == TERM) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign level = stable;

endmodule

// File: rtl/vm_input_conditioner.sv
// Debounces buttons and coin switches; serializes coin events
// so the controller sees one coin per cycle, highest value first.
module vm_input_conditioner
    import vm_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              L_button_raw,
    input  logic              R_button_raw,
    input  logic              C_button_raw,
    input  logic [3:0]        switch_raw,
    output logic              L_pulse,
    output logic              R_pulse,
    output logic              C_pulse,
    output logic [2:0]        btn_level,
    output logic [3:0]        switch_level,
    output logic              coin_valid,
    output logic [COIN_W-1:0] coin_value
);

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] level;
    logic [NUM_CH-1:0] pulse;
    logic [3:0]        coin_rise;
    logic [3:0]        pending;
    logic [3:0]        grant;

    assign raw = {switch_raw, C_button_raw, R_button_raw, L_button_raw};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        vm_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw[i]),
            .level(level[i]),
            .pulse(pulse[i])
        );
    end

    assign L_pulse      = pulse[CH_L];
    assign R_pulse      = pulse[CH_R];
    assign C_pulse      = pulse[CH_C];
    assign btn_level    = level[CH_C:CH_L];
    assign switch_level = level[CH_SW3:CH_SW0];
    assign coin_rise    = pulse[CH_SW3:CH_SW0];

    always_comb begin
        grant      = 4'b0000;
        coin_value = '0;
        if (pending[3]) begin
            grant      = 4'b1000;
            coin_value = COIN_VAL_20;
        end else if (pending[2]) begin
            grant      = 4'b0100;
            coin_value = COIN_VAL_10;
        end else if (pending[1]) begin
            grant      = 4'b0010;
            coin_value = COIN_VAL_5;
        end else if (pending[0]) begin
            grant      = 4'b0001;
            coin_value = COIN_VAL_1;
        end
    end

    assign coin_valid = |pending;

    // A new rise wins over a same-cycle grant of that bit
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 4'b0000;
        end else begin
            pending <= (pending & ~grant) | coin_rise;
        end
    end

endmodule

// File: tb/tb_vm_input_conditioner.sv
// Directed bench for vm_input_conditioner with DEBOUNCE_CYCLES=4:
// pulse latency, glitch rejection, coin ordering and reset.
module tb_vm_input_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic       L_button_raw, R_button_raw, C_button_raw;
    logic [3:0] switch_raw;
    logic       L_pulse, R_pulse, C_pulse;
    logic [2:0] btn_level;
    logic [3:0] switch_level;
    logic       coin_valid;
    logic [4:0] coin_value;

    int errors = 0;
    int checks = 0;

    int l_cnt = 0, r_cnt = 0, c_cnt = 0;
    int cyc = 0;
    int coin_n = 0;
    int coin_vals [16];
    int coin_cyc  [16];

    always #5 clk = ~clk;

    vm_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .L_button_raw(L_button_raw),
        .R_button_raw(R_button_raw),
        .C_button_raw(C_button_raw),
        .switch_raw  (switch_raw),
        .L_pulse     (L_pulse),
        .R_pulse     (R_pulse),
        .C_pulse     (C_pulse),
        .btn_level   (btn_level),
        .switch_level(switch_level),
        .coin_valid  (coin_valid),
        .coin_value  (coin_value)
    );

    always @(negedge clk) begin
        if (L_pulse) l_cnt++;
        if (R_pulse) r_cnt++;
        if (C_pulse) c_cnt++;
        if (coin_valid && coin_n < 16) begin
            coin_vals[coin_n] = int'(coin_value);
            coin_cyc[coin_n]  = cyc;
            coin_n++;
        end
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int base_l, base_r, base_c, base_n, sum;
    int exp_vals [4];

    initial begin
        exp_vals = '{20, 10, 5, 1};
        rst = 1'b1;
        L_button_raw = 1'b0;
        R_button_raw = 1'b0;
        C_button_raw = 1'b0;
        switch_raw   = 4'b0000;
        step(2);
        chk("rst_pulses", {L_pulse, R_pulse, C_pulse}, 3'b000);
        chk("rst_btn_level", btn_level, 3'b000);
        chk("rst_sw_level", switch_level, 4'b0000);
        chk("rst_coin_valid", coin_valid, 1'b0);
        rst = 1'b0;
        step(5);

        // 1: clean L press, 20 cycles, release
        base_l = l_cnt;
        L_button_raw = 1'b1;
        step(6);
        chk("t1_pulse_early", L_pulse, 1'b0);
        chk("t1_level", btn_level[0], 1'b1);
        step(1);
        chk("t1_pulse", L_pulse, 1'b1);
        step(1);
        chk("t1_pulse_one_cycle", L_pulse, 1'b0);
        step(12);
        L_button_raw = 1'b0;
        step(10);
        chk("t1_level_release", btn_level[0], 1'b0);
        chk("t1_pulse_count", l_cnt - base_l, 1);

        // 3: R glitch of 3 samples
        base_r = r_cnt;
        R_button_raw = 1'b1;
        step(3);
        R_button_raw = 1'b0;
        step(10);
        chk("t3_r_pulses", r_cnt - base_r, 0);
        chk("t3_r_level", btn_level[1], 1'b0);

        // 2: C bounces, then holds high
        base_c = c_cnt;
        for (int i = 0; i < 6; i++) begin
            C_button_raw = (i % 2 == 0);
            step(2);
        end
        chk("t2_no_bounce_pulse", c_cnt - base_c, 0);
        C_button_raw = 1'b1;
        step(6);
        chk("t2_pulse_early", C_pulse, 1'b0);
        step(1);
        chk("t2_pulse", C_pulse, 1'b1);
        step(5);
        chk("t2_pulse_count", c_cnt - base_c, 1);

        // 4: all four coins at once
        base_n = coin_n;
        switch_raw = 4'b1111;
        step(20);
        chk("t4_coin_count", coin_n - base_n, 4);
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_coin%0d", i), coin_vals[base_n + i],
                exp_vals[i]);
            sum += coin_vals[base_n + i];
        end
        for (int i = 1; i < 4; i++)
            chk($sformatf("t4_consec%0d", i),
                coin_cyc[base_n + i] - coin_cyc[base_n + i - 1], 1);
        chk("t4_total", sum, 36);
        chk("t4_sw_level", switch_level, 4'b1111);
        chk("t4_idle", coin_valid, 1'b0);

        // 5: reset during L debounce, L kept high
        C_button_raw = 1'b0;
        step(10);
        base_l = l_cnt;
        L_button_raw = 1'b1;
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t5_no_pulse_pre_rst", l_cnt - base_l, 0);
        chk("t5_level_after_rst", btn_level[0], 1'b0);
        chk("t5_sw_cleared", switch_level, 4'b0000);
        step(6);
        chk("t5_pulse_early", L_pulse, 1'b0);
        step(1);
        chk("t5_pulse", L_pulse, 1'b1);
        step(3);
        chk("t5_pulse_count", l_cnt - base_l, 1);

        // 6: L and C rise together
        L_button_raw = 1'b0;
        C_button_raw = 1'b0;
        step(12);
        base_l = l_cnt;
        base_c = c_cnt;
        L_button_raw = 1'b1;
        C_button_raw = 1'b1;
        step(6);
        chk("t6_early", {L_pulse, C_pulse}, 2'b00);
        step(1);
        chk("t6_both", {L_pulse, C_pulse}, 2'b11);
        step(1);
        chk("t6_after", {L_pulse, C_pulse}, 2'b00);
        chk("t6_l_count", l_cnt - base_l, 1);
        chk("t6_c_count", c_cnt - base_c, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
